dmem_responder: RTL and testbench

Memory-side responder for the pipeline's M-stage data port: it accepts load/store requests from the datapath, holds a word-organised RAM with byte-write strobes, and answers each request after a fixed, parameterised number of wait states. It drives a stall line back to the pipeline hazard logic while an access is outstanding, so the core can run against a multi-cycle data memory.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/bytewrite_ram.sv | 28 ++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory responder and its RAM.
package dmem_pkg;

    localparam int STRB_W = 4;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    // A word address is out of range when any bit above the RAM index is set.
    function automatic logic addr_out_of_range(input logic [29:0] waddr, input int aw);
        return (waddr >> aw) != 30'd0;
    endfunction

endpackage

// File: rtl/bytewrite_ram.sv
// Synchronous single-port RAM with a write enable per byte lane and a read enable.
module bytewrite_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [STRB_W-1:0] we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
        for (int i = 0; i < STRB_W; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, answers for one
// cycle, and stalls the pipeline while the access is outstanding.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_we,
    input  logic [STRB_W-1:0] req_wstrb,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_stall
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;
    logic              we_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [29:0]       waddr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              capture, go_resp, ram_re;
    logic              acc_we, acc_oor;
    logic [29:0]       acc_waddr;
    logic [STRB_W-1:0] ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    // In IDLE the live request describes the access (needed for a zero-wait read);
    // in every later state the captured copy does.
    assign acc_we    = (state_q == IDLE) ? req_we : we_q;
    assign acc_waddr = (state_q == IDLE) ? req_addr[31:2] : waddr_q;
    assign acc_oor   = addr_out_of_range(acc_waddr, ADDR_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        zero_d  = zero_q;
        capture = 1'b0;
        go_resp = 1'b0;
        ram_we  = '0;
        unique case (state_q)
            IDLE: begin
                if (req_en) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (we_q && !acc_oor) begin
                    ram_we = wstrb_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Response flags are latched on entry to RESP and held until the next one.
        if (go_resp) begin
            err_d  = acc_oor;
            zero_d = acc_we | acc_oor;
        end
    end

    assign ram_re = go_resp & ~zero_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            we_q    <= req_we;
            wstrb_q <= req_wstrb;
            waddr_q <= req_addr[31:2];
            wdata_q <= req_wdata;
        end
    end

    bytewrite_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .addr_i  (acc_waddr[ADDR_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = zero_q ? '0 : ram_rdata;
    assign resp_err   = err_q;
    assign mem_stall  = req_en & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder at WAIT_CYCLES 0, 1 and 3 against a word-array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en [3];
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready [3];
    logic        valid [3];
    logic        err   [3];
    logic        stall [3];
    logic [31:0] rdata [3];

    int          checks = 0;
    int          errors = 0;
    int          wc_of [3] = '{0, 1, 3};
    logic [31:0] model [3][16];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_wc0 (
        .clk(clk), .rst(rst), .req_en(req_en[0]), .req_we(req_we), .req_wstrb(req_wstrb),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[0]), .resp_valid(valid[0]),
        .resp_rdata(rdata[0]), .resp_err(err[0]), .mem_stall(stall[0]));

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_wc1 (
        .clk(clk), .rst(rst), .req_en(req_en[1]), .req_we(req_we), .req_wstrb(req_wstrb),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[1]), .resp_valid(valid[1]),
        .resp_rdata(rdata[1]), .resp_err(err[1]), .mem_stall(stall[1]));

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_wc3 (
        .clk(clk), .rst(rst), .req_en(req_en[2]), .req_we(req_we), .req_wstrb(req_wstrb),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[2]), .resp_valid(valid[2]),
        .resp_rdata(rdata[2]), .resp_err(err[2]), .mem_stall(stall[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transaction on DUT d, checked against the model; req_en is held through RESP.
    task automatic access(input int d, input bit we, input logic [3:0] strb, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        bit          oor;
        int          w;
        int          cyc;
        int          stalls;
        logic [31:0] exp_rd;
        oor    = (addr >= 32'h0000_1000);
        w      = int'((addr >> 2) & 32'h3FF);
        exp_rd = 32'h0;
        if (!oor && !we) exp_rd = model[d][w];
        @(negedge clk);
        req_we    = we;
        req_wstrb = strb;
        req_addr  = addr;
        req_wdata = wdata;
        req_en[d] = 1'b1;
        #1;
        check_eq($sformatf("ready_at_req_d%0d", d), 32'(ready[d]), 32'd1);
        cyc    = 0;
        stalls = 0;
        while (!valid[d] && cyc < 40) begin
            if (stall[d]) stalls++;
            @(negedge clk);
            req_we    = 1'($urandom);
            req_wstrb = 4'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            #1;
            cyc++;
        end
        check_eq($sformatf("latency_d%0d", d), 32'(cyc), 32'(wc_of[d] + 1));
        check_eq($sformatf("stall_cycles_d%0d", d), 32'(stalls), 32'(wc_of[d] + 1));
        check_eq($sformatf("stall_in_resp_d%0d", d), 32'(stall[d]), 32'd0);
        check_eq($sformatf("rdata_d%0d_a%h", d, addr), rdata[d], exp_rd);
        check_eq($sformatf("err_d%0d_a%h", d, addr), 32'(err[d]), 32'(oor));
        rd = rdata[d];
        er = err[d];
        if (we && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model[d][w][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        @(negedge clk);
        req_en[d] = 1'b0;
        #1;
        check_eq($sformatf("ready_after_d%0d", d), 32'(ready[d]), 32'd1);
        check_eq($sformatf("no_reaccept_d%0d", d), 32'(valid[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] prior;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] addr;

        for (int d = 0; d < 3; d++) req_en[d] = 1'b0;
        req_we    = 1'b0;
        req_wstrb = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("rst_ready_d%0d", d), 32'(ready[d]), 32'd1);
            check_eq($sformatf("rst_valid_d%0d", d), 32'(valid[d]), 32'd0);
            check_eq($sformatf("rst_rdata_d%0d", d), rdata[d], 32'd0);
            check_eq($sformatf("rst_stall_d%0d", d), 32'(stall[d]), 32'd0);
        end
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) access(d, 1'b1, 4'hF, 32'(w * 4), $urandom, rd, er);
        end

        access(1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, rd, er);
        access(1, 1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er);
        check_eq("load_deadbeef", rd, 32'hDEAD_BEEF);
        access(1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, rd, er);
        access(1, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, rd, er);
        access(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0, rd, er);
        check_eq("byte_strobe", rd, 32'h11BB_33DD);
        access(1, 1'b1, 4'b0000, 32'h0000_0020, 32'hFFFF_FFFF, rd, er);
        access(1, 1'b0, 4'h0, 32'h0000_0020, 32'h0, rd, er);
        check_eq("zero_strobe_noop", rd, 32'h11BB_33DD);
        access(1, 1'b0, 4'h0, 32'h0001_0000, 32'h0, rd, er);
        check_eq("oor_load_rdata", rd, 32'h0);
        check_eq("oor_load_err", 32'(er), 32'd1);
        prior = model[1][0];
        access(1, 1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D, rd, er);
        access(1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, rd, er);
        check_eq("oor_store_word0", rd, prior);

        access(1, 1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er);
        prior = model[1][1];
        @(negedge clk);
        req_we    = 1'b1;
        req_wstrb = 4'hF;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'h1234_5678;
        req_en[1] = 1'b1;
        @(negedge clk);
        #1;
        check_eq("in_wait_ready", 32'(ready[1]), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(ready[1]), 32'd1);
        check_eq("midrst_valid", 32'(valid[1]), 32'd0);
        check_eq("midrst_rdata", rdata[1], 32'd0);
        check_eq("midrst_err", 32'(err[1]), 32'd0);
        req_en[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b0, 4'h0, 32'h0000_0004, 32'h0, rd, er);
        check_eq("midrst_store_dropped", rd, prior);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                we   = 1'($urandom);
                strb = 4'($urandom);
                if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
                else addr = {20'h0, 10'($urandom_range(0, 15)), 2'($urandom)};
                access(d, we, strb, addr, $urandom, rd, er);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
